control_unit: RTL

- Multi-cycle FSM that sequences the 8-bit datapath (r0-r3, PC, IR, address register, Y and Z/O flag registers, bus1/bus2 muxes, ALU) through fetch, decode and execute.
- Drives every datapath load/select strobe and the memory write strobe.
- Consumes the IR contents and the registered zero/overflow flags.
- Sits beside the datapath in the processor top level; the memory is addressed by the datapath's address register.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/instr_decode.sv | 22 ++
 rtl/control_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, controller state encoding
// and the bus mux select codes used by both the controller and the datapath.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_NOT = 4'h4;
  localparam logic [OP_W-1:0] OP_RD  = 4'h5;
  localparam logic [OP_W-1:0] OP_WR  = 4'h6;
  localparam logic [OP_W-1:0] OP_BR  = 4'h7;
  localparam logic [OP_W-1:0] OP_BRZ = 4'h8;
  localparam logic [OP_W-1:0] OP_BRO = 4'h9;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [2:0] SEL1_PC   = 3'd4;
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  // Opcodes A..E have no meaning and halt the machine with an error.
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational split of the IR into opcode, register fields, one-hot
// destination load vector and illegal-opcode flag.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] instruction,
  output logic [3:0] opcode,
  output logic [1:0] src,
  output logic [1:0] dest,
  output logic [3:0] dest_load,
  output logic       illegal
);

  always_comb begin
    opcode    = instruction[7:4];
    src       = instruction[3:2];
    dest      = instruction[1:0];
    dest_load = 4'(1) << dest;
    illegal   = is_illegal(instruction[7:4]);
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the datapath strobes.
// Strobes are decoded from the current state and IR; only state and err are flops.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic       zero,
  input  logic       over,
  output logic       load_r0,
  output logic       load_r1,
  output logic       load_r2,
  output logic       load_r3,
  output logic       load_pc,
  output logic       inc_pc,
  output logic [2:0] s_b_mux1,
  output logic [1:0] s_b_mux2,
  output logic       load_ir,
  output logic       load_a_reg,
  output logic       load_reg_y,
  output logic       load_reg_z,
  output logic       write,
  output logic       halted,
  output logic       err
);

  state_t     state_q, state_d;
  logic       err_q, err_d;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;
  logic [3:0] dest_load;
  logic       illegal;
  logic [3:0] load_r;

  instr_decode u_instr_decode (
    .instruction (instruction),
    .opcode      (opcode),
    .src         (src),
    .dest        (dest),
    .dest_load   (dest_load),
    .illegal     (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    load_r     = 4'b0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    s_b_mux1   = 3'd0;
    s_b_mux2   = 2'd0;
    load_ir    = 1'b0;
    load_a_reg = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write      = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: begin
        s_b_mux1   = SEL1_PC;
        s_b_mux2   = SEL2_BUS1;
        load_a_reg = 1'b1;
        state_d    = S_FET2;
      end
      S_FET2: begin
        s_b_mux2 = SEL2_MEM;
        load_ir  = 1'b1;
        inc_pc   = 1'b1;
        state_d  = S_DEC;
      end
      S_DEC: begin
        state_d = S_FET1;
        case (opcode)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_AND: begin
            s_b_mux1   = 3'(src);
            s_b_mux2   = SEL2_BUS1;
            load_reg_y = 1'b1;
            state_d    = S_EX1;
          end
          OP_NOT: begin
            s_b_mux1   = 3'(src);
            s_b_mux2   = SEL2_ALU;
            load_reg_z = 1'b1;
            load_r     = dest_load;
          end
          OP_RD, OP_WR, OP_BR, OP_BRZ, OP_BRO: begin
            // Untaken conditional branches skip the operand byte instead.
            if ((opcode == OP_BRZ && !zero) || (opcode == OP_BRO && !over)) begin
              inc_pc = 1'b1;
            end else begin
              s_b_mux1   = SEL1_PC;
              s_b_mux2   = SEL2_BUS1;
              load_a_reg = 1'b1;
              state_d    = (opcode == OP_RD) ? S_RD1 :
                           (opcode == OP_WR) ? S_WR1 : S_BR1;
            end
          end
          default: begin
            state_d = S_HALT;
            err_d   = illegal;
          end
        endcase
      end
      S_EX1: begin
        s_b_mux1   = 3'(dest);
        s_b_mux2   = SEL2_ALU;
        load_reg_z = 1'b1;
        load_r     = dest_load;
        state_d    = S_FET1;
      end
      S_RD1, S_WR1: begin
        s_b_mux2   = SEL2_MEM;
        load_a_reg = 1'b1;
        inc_pc     = 1'b1;
        state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        s_b_mux2 = SEL2_MEM;
        load_r   = dest_load;
        state_d  = S_FET1;
      end
      S_WR2: begin
        s_b_mux1 = 3'(src);
        write    = 1'b1;
        state_d  = S_FET1;
      end
      S_BR1: begin
        s_b_mux2   = SEL2_MEM;
        load_a_reg = 1'b1;
        state_d    = S_BR2;
      end
      S_BR2: begin
        s_b_mux2 = SEL2_MEM;
        load_pc  = 1'b1;
        state_d  = S_FET1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_r0 = load_r[0];
  assign load_r1 = load_r[1];
  assign load_r2 = load_r[2];
  assign load_r3 = load_r[3];
  assign halted  = (state_q == S_HALT);
  assign err     = err_q && (state_q == S_HALT);

endmodule
